// File: rtl/sd_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_read_arbiter_if
//
// Bundles the requester side and the SD-reader side of the block-read
// arbiter into one interface.
//
//   Requester side : Req, ReqAddr0, ReqAddr1        (to arbiter)
//                    Grant, Data, DataValid,
//                    Done, Error                     (from arbiter)
//   Reader side    : SD_Ready, SD_Data,
//                    SD_DataValid                    (to arbiter)
//                    SD_Start, SD_Address            (from arbiter)
//
// Modports:
//   master : the environment (requesters plus SD reader)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface sd_read_arbiter_if;
    // Requester side
    logic [1:0]  Req;
    logic [23:0] ReqAddr0;
    logic [23:0] ReqAddr1;
    logic [1:0]  Grant;
    logic [7:0]  Data;
    logic [1:0]  DataValid;
    logic [1:0]  Done;
    logic [1:0]  Error;

    // SD reader side
    logic        SD_Ready;
    logic        SD_Start;
    logic [23:0] SD_Address;
    logic [7:0]  SD_Data;
    logic        SD_DataValid;

    modport master (
        output Req, ReqAddr0, ReqAddr1, SD_Ready, SD_Data, SD_DataValid,
        input  Grant, Data, DataValid, Done, Error, SD_Start, SD_Address
    );

    modport slave (
        input  Req, ReqAddr0, ReqAddr1, SD_Ready, SD_Data, SD_DataValid,
        output Grant, Data, DataValid, Done, Error, SD_Start, SD_Address
    );
endinterface

// File: rtl/sd_read_arbiter.sv
// ---------------------------------------------------------------------------
// sd_read_arbiter
//
// Shares one SD-over-SPI block reader between the video fetcher (port 0)
// and the audio fetcher (port 1). A round-robin winner is chosen in IDLE,
// its block address is registered onto SD_Address, the reader is kicked
// with a one-cycle SD_Start, and the returned byte stream is steered to the
// granted port. The transfer ends after BLOCK_BYTES bytes, or with an error
// when the reader stays silent for TIMEOUT_CYCLES (before the first byte or
// between bytes).
//
// Ports:
//   MasterCLK : system clock, rising edge
//   Reset     : asynchronous, active-low reset
//   bus       : sd_read_arbiter_if.slave (requester and reader signals)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module sd_read_arbiter #(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_BITS        = 20
) (
    input  logic              MasterCLK,
    input  logic              Reset,
    sd_read_arbiter_if.slave  bus
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT_FIRST = 3'd2;
    localparam logic [2:0] S_STREAM     = 3'd3;
    localparam logic [2:0] S_FINISH     = 3'd4;

    localparam logic [9:0]         BYTE_LIMIT = 10'(BLOCK_BYTES);
    localparam logic [TO_BITS-1:0] TO_LIMIT   = TO_BITS'(TIMEOUT_CYCLES);

    logic [2:0]         state_q,      state_d;
    logic [1:0]         grant_q,      grant_d;
    logic               last_grant_q, last_grant_d;   // 1: audio won last
    logic [23:0]        addr_q,       addr_d;
    logic               start_q,      start_d;
    logic [7:0]         data_q,       data_d;
    logic [1:0]         dv_q,         dv_d;
    logic [1:0]         done_q,       done_d;
    logic [1:0]         error_q,      error_d;
    logic               fail_q,       fail_d;         // current transfer failed
    logic [9:0]         byte_cnt_q,   byte_cnt_d;
    logic [TO_BITS-1:0] to_cnt_q,     to_cnt_d;

    logic               win_audio;
    logic [9:0]         byte_next;
    logic [TO_BITS-1:0] to_next;
    logic               to_expired;

    // Audio wins when it is the only requester, or when both request and
    // video was the previous winner.
    assign win_audio  = bus.Req[1] && (!bus.Req[0] || !last_grant_q);

    assign byte_next  = byte_cnt_q + 10'd1;
    // Saturating timeout counter: never wraps back below the limit.
    assign to_next    = (to_cnt_q == {TO_BITS{1'b1}}) ? to_cnt_q : to_cnt_q + 1'b1;
    assign to_expired = (to_next >= TO_LIMIT);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        start_d      = 1'b0;
        data_d       = data_q;
        dv_d         = 2'b00;
        done_d       = 2'b00;
        error_d      = 2'b00;
        fail_d       = fail_q;
        byte_cnt_d   = byte_cnt_q;
        to_cnt_d     = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.SD_Ready && (bus.Req != 2'b00)) begin
                    grant_d      = win_audio ? 2'b10 : 2'b01;
                    last_grant_d = win_audio;
                    addr_d       = win_audio ? bus.ReqAddr1 : bus.ReqAddr0;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                start_d    = 1'b1;
                byte_cnt_d = '0;
                to_cnt_d   = '0;
                fail_d     = 1'b0;
                state_d    = S_WAIT_FIRST;
            end

            // Both data states share the byte path; in WAIT_FIRST the byte
            // counter is still zero, so the first byte counts as byte 1.
            S_WAIT_FIRST, S_STREAM: begin
                if (bus.SD_DataValid) begin
                    byte_cnt_d = byte_next;
                    to_cnt_d   = '0;
                    // A requester that dropped Req mid-block still has its
                    // block drained from the reader, but sees no strobes.
                    if ((grant_q & bus.Req) != 2'b00) begin
                        data_d = bus.SD_Data;
                        dv_d   = grant_q & bus.Req;
                    end
                    state_d = (byte_next >= BYTE_LIMIT) ? S_FINISH : S_STREAM;
                end else if (to_expired) begin
                    fail_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    to_cnt_d = to_next;
                end
            end

            S_FINISH: begin
                done_d  = grant_q;
                error_d = fail_q ? grant_q : 2'b00;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            addr_q       <= 24'h000000;
            start_q      <= 1'b0;
            data_q       <= 8'h00;
            dv_q         <= 2'b00;
            done_q       <= 2'b00;
            error_q      <= 2'b00;
            fail_q       <= 1'b0;
            byte_cnt_q   <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            start_q      <= start_d;
            data_q       <= data_d;
            dv_q         <= dv_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fail_q       <= fail_d;
            byte_cnt_q   <= byte_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign bus.Grant      = grant_q;
    assign bus.Data       = data_q;
    assign bus.DataValid  = dv_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
    assign bus.SD_Start   = start_q;
    assign bus.SD_Address = addr_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_read_arbiter
//
// Drives both requesters and plays the SD reader. A negedge monitor logs
// every byte delivered to each port, every SD_Start cycle and any strobe on
// a non-granted port. The expected behaviour comes from a small model:
// round-robin winner from the request pattern, the byte list the reader
// sent while the owner still requested, and the latency rules (Done one
// cycle after the last byte, or TIMEOUT+1 cycles after the last activity).
// ---------------------------------------------------------------------------
module tb_sd_read_arbiter;

    localparam int TO = 100;
    localparam int BB = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sd_read_arbiter_if bus();

    sd_read_arbiter #(
        .BLOCK_BYTES    (BB),
        .TIMEOUT_CYCLES (TO),
        .TO_BITS        (20)
    ) dut (
        .MasterCLK (clk),
        .Reset     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor-owned records
    logic [7:0] rx_q0[$];
    logic [7:0] rx_q1[$];
    int         leak_cnt  = 0;
    int         start_cnt = 0;

    // Model-owned records
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    bit         model_last = 1'b1;

    // Observations of the latest transfer
    bit          obs_start;
    int          obs_start_ticks;
    logic [1:0]  obs_g1, obs_grant, obs_done, obs_err, obs_grant_done;
    logic [23:0] obs_addr;
    int          obs_lat, obs_starts;
    int          base0, base1;

    always @(negedge clk) begin
        if (bus.DataValid[0]) rx_q0.push_back(bus.Data);
        if (bus.DataValid[1]) rx_q1.push_back(bus.Data);
        if (((bus.DataValid & ~bus.Grant) != 2'b00) || (bus.DataValid == 2'b11))
            leak_cnt++;
        if (bus.SD_Start) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: with both requesting, the one that did not win
    // last time wins; otherwise the sole requester wins.
    function automatic int pick(input logic [1:0] req);
        int w;
        if (req == 2'b11) w = model_last ? 0 : 1;
        else              w = req[1] ? 1 : 0;
        model_last = (w == 1);
        return w;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // Mismatch count between what the reader sent (model) and what the
    // monitor saw on both ports since the transfer began.
    function automatic int stream_errors();
        int e;
        int n0;
        int n1;
        e  = 0;
        n0 = rx_q0.size() - base0;
        n1 = rx_q1.size() - base1;
        e += (n0 > exp_q0.size()) ? n0 - exp_q0.size() : exp_q0.size() - n0;
        e += (n1 > exp_q1.size()) ? n1 - exp_q1.size() : exp_q1.size() - n1;
        for (int i = 0; i < n0 && i < exp_q0.size(); i++)
            if (rx_q0[base0 + i] !== exp_q0[i]) e++;
        for (int i = 0; i < n1 && i < exp_q1.size(); i++)
            if (rx_q1[base1 + i] !== exp_q1[i]) e++;
        return e;
    endfunction

    task automatic do_reset();
        bus.Req          = 2'b00;
        bus.SD_DataValid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        model_last = 1'b1;
        tick();
    endtask

    // Reader model for one transfer on port g: waits for SD_Start, sends
    // nbytes with random 0..2 cycle gaps, optionally drops Req after byte
    // drop_after, then waits for Done. Records observations only.
    task automatic serve(input int g, input int nbytes, input int drop_after,
                         input bit pattern, input bit keep_req);
        int s0;
        logic [7:0] b;
        exp_q0.delete();
        exp_q1.delete();
        base0 = rx_q0.size();
        base1 = rx_q1.size();
        s0 = start_cnt;
        obs_done = 2'b00; obs_err = 2'b00; obs_grant_done = 2'b11; obs_lat = 0;
        tick();
        obs_g1 = bus.Grant;
        obs_start_ticks = 1;
        obs_start = bus.SD_Start;
        while (!obs_start && obs_start_ticks < 20) begin
            tick();
            obs_start_ticks++;
            obs_start = bus.SD_Start;
        end
        obs_grant = bus.Grant;
        obs_addr  = bus.SD_Address;
        if (obs_start) begin
            for (int i = 0; i < nbytes; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                b = pattern ? 8'(i) : 8'($urandom);
                bus.SD_Data = b;
                bus.SD_DataValid = 1'b1;
                if (bus.Req[g]) begin
                    if (g == 0) exp_q0.push_back(b);
                    else        exp_q1.push_back(b);
                end
                tick();
                bus.SD_DataValid = 1'b0;
                if (drop_after > 0 && i + 1 == drop_after) bus.Req[g] = 1'b0;
            end
            while (obs_done == 2'b00 && obs_lat < 300) begin
                tick();
                obs_lat++;
                obs_done = bus.Done;
                obs_err  = bus.Error;
                obs_grant_done = bus.Grant;
            end
        end
        if (!keep_req) bus.Req[g] = 1'b0;
        obs_starts = start_cnt - s0;
        $display("xfer port=%0d addr=%h start_ticks=%0d bytes0=%0d bytes1=%0d done=%b err=%b lat=%0d",
                 g, obs_addr, obs_start_ticks, rx_q0.size() - base0, rx_q1.size() - base1,
                 obs_done, obs_err, obs_lat);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        bus.Req = 2'b00; bus.ReqAddr0 = '0; bus.ReqAddr1 = '0;
        bus.SD_Ready = 1'b1; bus.SD_Data = '0; bus.SD_DataValid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({bus.Grant, bus.DataValid, bus.Done, bus.Error, bus.SD_Start,
             bus.SD_Address, bus.Data} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b dv=%b done=%b err=%b start=%b addr=%h data=%h, required all zero",
                     bus.Grant, bus.DataValid, bus.Done, bus.Error, bus.SD_Start, bus.SD_Address, bus.Data);
        end
        rst_n = 1'b1;
        model_last = 1'b1;
        tick();
    endtask

    task automatic test_single_video();
        int g;
        bus.ReqAddr0 = 24'h000123;
        bus.ReqAddr1 = 24'($urandom);
        bus.Req = 2'b01;
        g = pick(2'b01);
        serve(g, BB, 0, 1'b1, 1'b0);
        n_checks++;
        if (obs_g1 !== 2'b01) begin n_fail++;
            $display("FAIL single_grant_latency: grant one edge after Req %b, required 01", obs_g1); end
        n_checks++;
        if (obs_start_ticks !== 2) begin n_fail++;
            $display("FAIL single_start_latency: SD_Start after %0d edges, required 2", obs_start_ticks); end
        n_checks++;
        if (obs_addr !== 24'h000123) begin n_fail++;
            $display("FAIL single_address: got %h required 000123", obs_addr); end
        n_checks++;
        if (obs_starts !== 1) begin n_fail++;
            $display("FAIL single_start_count: got %0d cycles of SD_Start, required 1", obs_starts); end
        n_checks++;
        if (rx_q0.size() - base0 !== BB || stream_errors() !== 0) begin n_fail++;
            $display("FAIL single_stream: got %0d bytes, %0d errors, required %0d bytes 0 errors",
                     rx_q0.size() - base0, stream_errors(), BB); end
        n_checks++;
        if (obs_done !== 2'b01 || obs_err !== 2'b00 || obs_lat !== 1) begin n_fail++;
            $display("FAIL single_done: got done=%b err=%b lat=%0d, required 01 00 1",
                     obs_done, obs_err, obs_lat); end
    endtask

    task automatic test_contention();
        int g;
        logic [23:0] a0, a1;
        do_reset();
        a0 = 24'($urandom); a1 = 24'($urandom);
        bus.ReqAddr0 = a0; bus.ReqAddr1 = a1;
        bus.Req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            g = pick(2'b11);
            serve(g, BB, 0, 1'b0, (k < 2));
            if (k == 2) bus.Req = 2'b00;
            n_checks++;
            if (obs_grant !== onehot(g) || obs_addr !== (g == 1 ? a1 : a0)) begin n_fail++;
                $display("FAIL contention_grant k=%0d: got grant=%b addr=%h, required %b %h",
                         k, obs_grant, obs_addr, onehot(g), (g == 1 ? a1 : a0)); end
            n_checks++;
            if (stream_errors() !== 0 || obs_done !== onehot(g) || obs_err !== 2'b00) begin n_fail++;
                $display("FAIL contention_xfer k=%0d: stream errors %0d done=%b err=%b, required 0 %b 00",
                         k, stream_errors(), obs_done, obs_err, onehot(g)); end
            n_checks++;
            if (obs_grant_done !== 2'b00 || obs_start_ticks !== 2) begin n_fail++;
                $display("FAIL contention_gap k=%0d: grant at Done %b, start ticks %0d, required 00 and 2",
                         k, obs_grant_done, obs_start_ticks); end
        end
        n_checks++;
        if (leak_cnt !== 0) begin n_fail++;
            $display("FAIL contention_leak: got %0d strobes on non-granted port, required 0", leak_cnt); end
    endtask

    task automatic test_first_timeout();
        int g;
        g = $urandom_range(0, 1);
        bus.ReqAddr0 = 24'($urandom); bus.ReqAddr1 = 24'($urandom);
        bus.Req = onehot(g);
        g = pick(onehot(g));
        serve(g, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if (!obs_start || obs_lat !== TO + 1) begin n_fail++;
            $display("FAIL first_timeout_latency: start=%0d Done after %0d cycles, required %0d",
                     obs_start, obs_lat, TO + 1); end
        n_checks++;
        if (obs_done !== onehot(g) || obs_err !== onehot(g) || obs_grant_done !== 2'b00) begin n_fail++;
            $display("FAIL first_timeout_flags: done=%b err=%b grant=%b, required %b %b 00",
                     obs_done, obs_err, obs_grant_done, onehot(g), onehot(g)); end
    endtask

    task automatic test_mid_stall();
        int g;
        g = $urandom_range(0, 1);
        bus.ReqAddr0 = 24'($urandom); bus.ReqAddr1 = 24'($urandom);
        bus.Req = onehot(g);
        g = pick(onehot(g));
        serve(g, 300, 0, 1'b0, 1'b0);
        n_checks++;
        if ((rx_q0.size() - base0) + (rx_q1.size() - base1) !== 300 || stream_errors() !== 0) begin n_fail++;
            $display("FAIL stall_bytes: got %0d bytes, %0d errors, required 300 and 0",
                     (rx_q0.size() - base0) + (rx_q1.size() - base1), stream_errors()); end
        n_checks++;
        if (obs_done !== onehot(g) || obs_err !== onehot(g) || obs_lat !== TO + 1) begin n_fail++;
            $display("FAIL stall_error: done=%b err=%b lat=%0d, required %b %b %0d",
                     obs_done, obs_err, obs_lat, onehot(g), onehot(g), TO + 1); end
        // Next request is served normally
        g = $urandom_range(0, 1);
        bus.Req = onehot(g);
        g = pick(onehot(g));
        serve(g, BB, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== onehot(g) || stream_errors() !== 0 || obs_done !== onehot(g) || obs_err !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_recovery: grant=%b errors=%0d done=%b err=%b, required %b 0 %b 00",
                     obs_grant, stream_errors(), obs_done, obs_err, onehot(g), onehot(g)); end
    endtask

    task automatic test_req_drop();
        int g;
        do_reset();
        bus.ReqAddr0 = 24'($urandom); bus.ReqAddr1 = 24'($urandom);
        bus.Req = 2'b11;
        g = pick(2'b11);
        serve(g, BB, 10, 1'b0, 1'b0);
        n_checks++;
        if (rx_q0.size() - base0 !== 10 || stream_errors() !== 0) begin n_fail++;
            $display("FAIL drop_strobes: got %0d bytes to video, %0d errors, required 10 and 0",
                     rx_q0.size() - base0, stream_errors()); end
        n_checks++;
        if (obs_done !== 2'b01 || obs_err !== 2'b00 || obs_lat !== 1) begin n_fail++;
            $display("FAIL drop_done: done=%b err=%b lat=%0d, required 01 00 1", obs_done, obs_err, obs_lat); end
        g = pick(bus.Req);
        serve(g, BB, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b10 || obs_addr !== bus.ReqAddr1 || stream_errors() !== 0) begin n_fail++;
            $display("FAIL drop_next_audio: grant=%b addr=%h errors=%0d, required 10 %h 0",
                     obs_grant, obs_addr, stream_errors(), bus.ReqAddr1); end
    endtask

    task automatic test_async_reset();
        int g;
        int waited;
        logic [1:0] dv_before;
        do_reset();
        bus.ReqAddr0 = 24'($urandom); bus.ReqAddr1 = 24'($urandom);
        bus.Req = 2'b01;
        g = pick(2'b01);
        waited = 0;
        while (!bus.SD_Start && waited < 20) begin tick(); waited++; end
        for (int i = 0; i < 200; i++) begin
            bus.SD_Data = 8'($urandom);
            bus.SD_DataValid = 1'b1;
            tick();
            bus.SD_DataValid = 1'b0;
        end
        dv_before = bus.DataValid;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dv_before !== 2'b01) begin n_fail++;
            $display("FAIL async_pre: DataValid before reset %b, required 01", dv_before); end
        n_checks++;
        if ({bus.Grant, bus.DataValid, bus.Done, bus.Error, bus.SD_Start,
             bus.SD_Address, bus.Data} !== 41'd0) begin n_fail++;
            $display("FAIL async_immediate: grant=%b dv=%b done=%b err=%b start=%b addr=%h data=%h, required all zero",
                     bus.Grant, bus.DataValid, bus.Done, bus.Error, bus.SD_Start, bus.SD_Address, bus.Data); end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_last = 1'b1;
        bus.Req = 2'b10;
        g = pick(2'b10);
        serve(g, BB, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b10 || obs_starts !== 1 || obs_start_ticks !== 2 || obs_addr !== bus.ReqAddr1) begin
            n_fail++;
            $display("FAIL async_regrant: grant=%b starts=%0d ticks=%0d addr=%h, required 10 1 2 %h",
                     obs_grant, obs_starts, obs_start_ticks, obs_addr, bus.ReqAddr1); end
        n_checks++;
        if (stream_errors() !== 0 || obs_done !== 2'b10 || obs_err !== 2'b00) begin n_fail++;
            $display("FAIL async_xfer: errors=%0d done=%b err=%b, required 0 10 00",
                     stream_errors(), obs_done, obs_err); end
    endtask

    task automatic test_not_ready_and_stray();
        int s0;
        int r0;
        int r1;
        s0 = start_cnt; r0 = rx_q0.size(); r1 = rx_q1.size();
        // Stray reader bytes while idle
        for (int i = 0; i < 3; i++) begin
            bus.SD_Data = 8'($urandom);
            bus.SD_DataValid = 1'b1;
            tick();
            bus.SD_DataValid = 1'b0;
            tick();
        end
        // Requests held off while the reader is not ready
        bus.SD_Ready = 1'b0;
        bus.Req = 2'b01;
        repeat (5) tick();
        n_checks++;
        if (bus.Grant !== 2'b00 || start_cnt !== s0 || rx_q0.size() !== r0 || rx_q1.size() !== r1) begin
            n_fail++;
            $display("FAIL idle_hold: grant=%b starts=%0d bytes=%0d, required 00 0 0",
                     bus.Grant, start_cnt - s0, (rx_q0.size() - r0) + (rx_q1.size() - r1)); end
        bus.SD_Ready = 1'b1;
        serve(pick(2'b01), BB, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs_grant !== 2'b01 || stream_errors() !== 0 || obs_done !== 2'b01) begin n_fail++;
            $display("FAIL ready_release: grant=%b errors=%0d done=%b, required 01 0 01",
                     obs_grant, stream_errors(), obs_done); end
    endtask

    initial begin
        test_reset();
        test_single_video();
        test_contention();
        test_first_timeout();
        test_mid_stall();
        test_req_drop();
        test_async_reset();
        test_not_ready_and_stray();
        n_checks++;
        if (leak_cnt !== 0) begin n_fail++;
            $display("FAIL final_leak: got %0d strobes on non-granted port, required 0", leak_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_read_arbiter.md
# sd_read_arbiter

Schedules 512-byte block reads on the shared SD-over-SPI reader between two requesters, the video frame fetcher (port 0) and the audio sample fetcher (port 1). Arbitrates round-robin, presents the winner's block address to the reader, steers the returned byte stream to the granted requester, and checks byte count and timeout. Sits between the SD_SPI reader and the audio/video buffer fillers in the Peripheral_AudVid subsystem.

## Interface
- `BLOCK_BYTES`, default 512: bytes per block read.
- `TIMEOUT_CYCLES`, default 1_000_000: max MasterCLK cycles from `SD_Start` to the first byte, and between consecutive bytes.
- `TO_BITS`, default 20: width of the timeout counter.

Ports:
- `MasterCLK` input 1: single system clock; all logic on its rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Req` input 2: per-requester read request (bit 0 video, bit 1 audio); level, held until `Done`.
- `ReqAddr0`, `ReqAddr1` input 24 each: block address of each requester; sampled at grant.
- `Grant` output 2: one-hot, the requester owning the current transfer.
- `Data` output 8: byte routed to the granted requester.
- `DataValid` output 2: one-cycle strobe per byte, to the granted requester only.
- `Done` output 2: one-cycle pulse at the end of a transfer.
- `Error` output 2: one-cycle pulse with `Done` when the transfer failed.
- `SD_Ready` input 1: the reader is initialized and idle.
- `SD_Start` output 1: one-cycle command pulse to the reader.
- `SD_Address` output 24: registered block address; stable from `SD_Start` until `Done`.
- `SD_Data` input 8: byte from the reader.
- `SD_DataValid` input 1: one-cycle byte strobe, synchronous to MasterCLK.

## Operation
- **States:** IDLE, ISSUE, WAIT_FIRST, STREAM, FINISH.
- **IDLE:**
  - If `SD_Ready` and any `Req` bit is set, pick the winner round-robin. `LastGrant` (1 bit, reset 1) marks the previous winner; when both request, the requester other than `LastGrant` wins.
  - Latch the winner's address into `SD_Address`, set `Grant`, update `LastGrant`, go to ISSUE.
- **ISSUE:** assert `SD_Start` for exactly one cycle, clear the byte and timeout counters, go to WAIT_FIRST.
- **WAIT_FIRST:** the first `SD_DataValid` moves to STREAM and counts as byte 1. If the timeout counter reaches `TIMEOUT_CYCLES`, go to FINISH with error.
- **STREAM:**
  - Each `SD_DataValid` forwards `SD_Data`, pulses `DataValid[g]` and increments the 10-bit byte counter. The timeout counter restarts on every byte.
  - When the counter reaches `BLOCK_BYTES`, go to FINISH with no error.
  - If the timeout expires first, go to FINISH with error.
- **FINISH:** pulse `Done[g]`, and `Error[g]` if the transfer failed. Clear `Grant`, return to IDLE.
- **Request drop:** if the granted `Req` drops mid-transfer, the block is still completed. Bytes are discarded (no `DataValid`); `Done` still pulses.
- **Stray bytes:** `SD_DataValid` in IDLE, ISSUE or FINISH is ignored.
- **Asynchronous reset** from any state:
  - State goes to IDLE. `Grant`, `DataValid`, `Done`, `Error` and `SD_Start` go to 0.
  - `SD_Address` goes to 0, `Data` to 0x00, `LastGrant` to 1, counters to 0.
  - Reset mid-block abandons the block; the reader is re-synchronized externally.

## Timing
- Grant latency: `Req` sampled in IDLE → `Grant` and `SD_Address` valid on the next edge → `SD_Start` one cycle after that.
- `Data` and `DataValid` are registered: one cycle after `SD_DataValid`.
- `Done` is asserted the cycle after the final `DataValid`.
- Minimum idle gap between transfers: one cycle (the FINISH → IDLE edge).
- Back-to-back: a requester still holding `Req` after `Done` loses to a waiting other requester.
- Timeout compare is `>=`; the counter saturates and does not wrap.
- A timeout abort emits at most `BLOCK_BYTES-1` bytes.

## Test plan
- **Single video read:** `Req=01`, `ReqAddr0=0x000123`, reader returns 512 bytes 0x00..0xFF repeating.
  - `SD_Start` fires once with `SD_Address=0x000123`.
  - 512 `DataValid[0]` strobes carry the correct bytes, then `Done=01` and `Error=00`.
- **Contention:** `Req=11` from reset.
  - Audio loses first, since `LastGrant=1` means video wins: grants run 01, 10, 01 across three back-to-back blocks.
  - No `DataValid` appears on the non-granted port.
- **First-byte timeout:** `TIMEOUT_CYCLES=100`, reader silent.
  - `Done[g]` and `Error[g]` pulse exactly 101 cycles after `SD_Start`, then state returns to IDLE.
- **Mid-block stall:** reader stops after 300 bytes, `TIMEOUT_CYCLES=100`.
  - 300 strobes, then `Error` pulses with `Done`.
  - A following request is served normally.
- **Request drop:** video drops `Req` after byte 10.
  - `DataValid` stops; the block is consumed to 512 bytes, `Done[0]` pulses, and audio is granted next.
- **Async reset:** assert `Reset` low at byte 200 for 3 cycles.
  - All outputs go 0 immediately, without waiting for a clock edge.
  - After release, `Req=10` is granted audio with a fresh `SD_Start`.
